ps2_device_port: RTL

// Device-side PS/2 endpoint (keyboard/mouse emulator) for the other end of the system's PS/2 host ports.

---
 rtl/ps2_device_port_if.sv | 34 +++
 rtl/ps2_device_port.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_port_if.sv
// PS/2 device port bundle: byte-level TX/RX handshake plus the open-drain pad view.
// Latency: none, wires only.
// Backpressure: tx_valid/tx_ready handshake; RX side is a pulse with no backpressure.
// Ports: tx_data/tx_valid/tx_ready/tx_abort, rx_data/rx_valid/rx_parity_err/rx_frame_err,
//        busy, ps2_clk_in/ps2_dat_in (pad levels), ps2_clk_oe/ps2_dat_oe (pull-low enables).
interface ps2_device_port_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_abort;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    // master: the system side that supplies bytes and the pad levels
    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        input  tx_ready, tx_abort, rx_data, rx_valid, rx_parity_err,
               rx_frame_err, busy, ps2_clk_oe, ps2_dat_oe
    );

    // slave: the device-side PS/2 endpoint
    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        output tx_ready, tx_abort, rx_data, rx_valid, rx_parity_err,
               rx_frame_err, busy, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_device_port.sv
// Device-side PS/2 endpoint: generates PS/2 CLK, sends device->host bytes, receives host commands and ACKs them.
// Latency: accept -> first CLK fall = IDLE_HOLD+HALF_PER+2 cycles; one frame = 22*HALF_PER cycles.
// Backpressure: tx_ready only in IDLE with nothing pending; a host inhibit aborts and retries the whole frame.
// Ports: clk_i, rst_i (async active-high), bus (slave modport: TX/RX handshake, status, pad levels and pull-low enables).
module ps2_device_port #(
    parameter int HALF_PER  = 2000,
    parameter int IDLE_HOLD = 2500,
    parameter int RTS_MIN   = 4000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ps2_device_port_if.slave     bus
);
    localparam int CMAX = (HALF_PER > IDLE_HOLD) ? HALF_PER : IDLE_HOLD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int LW   = $clog2(RTS_MIN + 1);
    localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PER - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(IDLE_HOLD);
    localparam logic [LW-1:0] RTS_END  = LW'(RTS_MIN);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, TX_WAIT, TX_BIT, TX_END, RX_BIT, RX_ACK
    } state_t;

    logic          clk_m_q, clk_s_q, dat_m_q, dat_s_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic          phase_b_q;        // 0 = phase A (CLK released), 1 = phase B (CLK low)
    logic [10:0]   frame_q;
    logic          pend_q;
    logic [8:0]    rx_sh_q;
    logic [LW-1:0] lowcnt_q, lowcnt_d;
    logic          clk_oe_q, dat_oe_q;
    logic          tx_abort_q, rx_valid_q, rx_par_err_q, rx_frame_err_q;
    logic [7:0]    rx_data_q;
    logic          tx_ready_w, rts_w, half_end_w;

    assign tx_ready_w = (state_q == IDLE) && !pend_q;
    assign rts_w      = (lowcnt_q == RTS_END);
    assign half_end_w = (cnt_q == HP_LAST);

    assign bus.tx_ready      = tx_ready_w;
    assign bus.busy          = (state_q != IDLE);
    assign bus.tx_abort      = tx_abort_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_parity_err = rx_par_err_q;
    assign bus.rx_frame_err  = rx_frame_err_q;
    assign bus.ps2_clk_oe    = clk_oe_q;
    assign bus.ps2_dat_oe    = dat_oe_q;

    // Pads idle high, so the synchronisers reset to 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_m_q <= 1'b1;
            clk_s_q <= 1'b1;
            dat_m_q <= 1'b1;
            dat_s_q <= 1'b1;
        end else begin
            clk_m_q <= bus.ps2_clk_in;
            clk_s_q <= clk_m_q;
            dat_m_q <= bus.ps2_dat_in;
            dat_s_q <= dat_m_q;
        end
    end

    // Host CLK-low qualifier; only meaningful while we are not driving CLK ourselves.
    always_comb begin
        lowcnt_d = '0;
        if ((state_q == IDLE || state_q == TX_WAIT) && !clk_s_q)
            lowcnt_d = rts_w ? RTS_END : lowcnt_q + LW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lowcnt_q <= '0;
        else       lowcnt_q <= lowcnt_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            phase_b_q      <= 1'b0;
            frame_q        <= '0;
            pend_q         <= 1'b0;
            rx_sh_q        <= '0;
            clk_oe_q       <= 1'b0;
            dat_oe_q       <= 1'b0;
            tx_abort_q     <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_par_err_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_data_q      <= '0;
        end else begin
            tx_abort_q     <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.tx_valid && tx_ready_w) begin
                        frame_q <= {1'b1, ~^bus.tx_data, bus.tx_data, 1'b0};
                        pend_q  <= 1'b1;
                        state_q <= rts_w ? INHIBIT : TX_WAIT;
                    end else if (rts_w) begin
                        state_q <= INHIBIT;
                    end
                end
                TX_WAIT: begin
                    if (rts_w) begin
                        cnt_q   <= '0;
                        state_q <= INHIBIT;
                    end else if (clk_s_q && dat_s_q) begin
                        if (cnt_q == HOLD_END) begin
                            cnt_q     <= '0;
                            bit_q     <= '0;
                            phase_b_q <= 1'b0;
                            dat_oe_q  <= ~frame_q[0];
                            state_q   <= TX_BIT;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                INHIBIT: begin
                    cnt_q <= '0;
                    if (clk_s_q) begin
                        if (!dat_s_q) begin
                            // Host request-to-send: DAT low is the start bit, clock the data in.
                            bit_q     <= '0;
                            phase_b_q <= 1'b1;
                            clk_oe_q  <= 1'b1;
                            state_q   <= RX_BIT;
                        end else begin
                            state_q <= pend_q ? TX_WAIT : IDLE;
                        end
                    end
                end
                TX_BIT: begin
                    if (!half_end_w) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        if (!phase_b_q) begin
                            // CLK still low at the end of our released half: host is inhibiting.
                            // Bit 10 is committed and never aborted.
                            if (!clk_s_q && bit_q != 4'd10) begin
                                dat_oe_q   <= 1'b0;
                                tx_abort_q <= 1'b1;
                                state_q    <= TX_WAIT;
                            end else begin
                                phase_b_q <= 1'b1;
                                clk_oe_q  <= 1'b1;
                            end
                        end else begin
                            clk_oe_q  <= 1'b0;
                            phase_b_q <= 1'b0;
                            if (bit_q == 4'd10) begin
                                dat_oe_q <= 1'b0;
                                state_q  <= TX_END;
                            end else begin
                                bit_q    <= bit_q + 4'd1;
                                dat_oe_q <= ~frame_q[bit_q + 4'd1];
                            end
                        end
                    end
                end
                TX_END: begin
                    if (!half_end_w) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RX_BIT: begin
                    if (!half_end_w) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        if (phase_b_q) begin
                            phase_b_q <= 1'b0;
                            clk_oe_q  <= 1'b0;
                        end else if (bit_q == 4'd9) begin
                            // Stop bit is judged directly; data and parity already shifted in.
                            if (dat_s_q) begin
                                bit_q    <= '0;
                                dat_oe_q <= 1'b1;
                                state_q  <= RX_ACK;
                            end else begin
                                rx_frame_err_q <= 1'b1;
                                state_q        <= pend_q ? TX_WAIT : IDLE;
                            end
                        end else begin
                            rx_sh_q   <= {dat_s_q, rx_sh_q[8:1]};
                            bit_q     <= bit_q + 4'd1;
                            phase_b_q <= 1'b1;
                            clk_oe_q  <= 1'b1;
                        end
                    end
                end
                RX_ACK: begin
                    // bit_q steps through: released half, CLK-low half, released half.
                    if (!half_end_w) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        case (bit_q)
                            4'd0: begin
                                bit_q    <= 4'd1;
                                clk_oe_q <= 1'b1;
                            end
                            4'd1: begin
                                bit_q    <= 4'd2;
                                clk_oe_q <= 1'b0;
                            end
                            default: begin
                                dat_oe_q     <= 1'b0;
                                rx_valid_q   <= 1'b1;
                                rx_data_q    <= rx_sh_q[7:0];
                                rx_par_err_q <= ~(^rx_sh_q);
                                state_q      <= pend_q ? TX_WAIT : IDLE;
                            end
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
